// File: rtl/vga_pkg.sv
// Default 640x480 @ 60 Hz timing constants (50 MHz system clock) and count-window helper
// shared by the VGA sync generator and its pixel divider.
package vga_pkg;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned DIV_W     = 4;
    localparam int unsigned FC_W      = 8;
    localparam int unsigned MAX_TOTAL = 1 << CNT_W;

    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CLK_DIV   = 2;

    localparam int unsigned DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Count c lies in [lo, hi); evaluated in 32 bits so hi may reach 2**CNT_W.
    function automatic logic in_window(input logic [CNT_W-1:0] c,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (32'(c) >= lo) && (32'(c) < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to the pixel rate; p_tick is a registered one-clk strobe
// that is high while the divider sits on its last count (constantly high when CLK_DIV=1).
module pixel_tick_div
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("pixel_tick_div: CLK_DIV=%0d outside 1..16", CLK_DIV);
    end

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = div_cnt + DIV_W'(1);
        if (div_cnt == DIV_LAST) begin
            div_next = '0;
        end
    end

    // Strobe is decoded from the next count so it is aligned with div_cnt == CLK_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            p_tick  <= (CLK_DIV == 1);
        end else begin
            div_cnt <= div_next;
            p_tick  <= (div_next == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters, registered sync/blank decode, frame pulse.
// Define VGA_SYNC_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_count is 0.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_LO   = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_HI   = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int unsigned VS_LO   = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_HI   = V_DISPLAY + V_FRONT + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL=%0d V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
    end

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick)
    );

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             frame_wrap;

    always_comb begin
        h_next = pixel_x;
        v_next = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_LAST) begin
                h_next = '0;
                v_next = (pixel_y == V_LAST) ? '0 : pixel_y + CNT_W'(1);
            end else begin
                h_next = pixel_x + CNT_W'(1);
            end
        end
    end

    assign frame_wrap = p_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);

    // Decode the next count so sync/blank flops change together with the coordinates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= h_next;
            pixel_y     <= v_next;
            video_on    <= in_window(h_next, 0, H_DISPLAY) && in_window(v_next, 0, V_DISPLAY);
            hsync       <= !in_window(h_next, HS_LO, HS_HI);
            vsync       <= !in_window(v_next, VS_LO, VS_HI);
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (frame_wrap) begin
            frame_count <= frame_count + FC_W'(1);
        end
    end
`else
    assign frame_count = FC_W'(0);
`endif

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the VGA output path: divides the system clock to the pixel rate, runs the horizontal and vertical counters, and produces `pixel_x`, `pixel_y`, `video_on`, `hsync` and `vsync`. It sits directly upstream of the colour-selection stage, which consumes `pixel_x`/`pixel_y`/`video_on`, and of the text and graphics generators, which index their ROMs with the same coordinates. Default timing is 640x480 at 60 Hz from a 50 MHz clock.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48, horizontal porch and sync widths in pixels
- `V_DISPLAY`, 480, visible lines
- `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33, vertical porch and sync widths in lines
- `CLK_DIV`, 2, system clocks per pixel (range 1 to 16)
- `clk` in 1, system clock
- `reset_n` in 1, asynchronous, active-low reset
- `p_tick` out 1, pixel-enable strobe, high for one `clk` cycle per pixel
- `pixel_x` out 10, current horizontal count (0 to H_TOTAL-1)
- `pixel_y` out 10, current vertical count (0 to V_TOTAL-1)
- `video_on` out 1, high when the current pixel is inside the visible area
- `hsync` out 1, horizontal sync, active-low
- `vsync` out 1, vertical sync, active-low
- `frame_start` out 1, one-`clk` pulse when the counters enter (0,0)
- `frame_count` out 8, frame counter (see Configuration)

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525 by default).
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `p_tick` = (`div_cnt` == CLK_DIV-1). When CLK_DIV=1, `p_tick` is constantly 1 out of reset.
- On a `clk` edge with `p_tick` high, `h_cnt` increments. At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments. `v_cnt` wraps to 0 at V_TOTAL-1, on the same edge that `h_cnt` wraps.
- `hsync` is 0 when H_DISPLAY+H_FRONT ≤ `h_cnt` < H_DISPLAY+H_FRONT+H_SYNC (656..751 by default). Otherwise it is 1.
- `vsync` is 0 when V_DISPLAY+V_FRONT ≤ `v_cnt` < V_DISPLAY+V_FRONT+V_SYNC (490..491 by default). Otherwise it is 1.
- `video_on` = (`h_cnt` < H_DISPLAY) && (`v_cnt` < V_DISPLAY).
- `hsync`, `vsync` and `video_on` are flops loaded from the next-count decode. They change on the same edge as `pixel_x`/`pixel_y` and are glitch-free.
- `frame_start` is a flop. It is high for exactly the one `clk` cycle after the edge that loads (0,0).
- Counter arithmetic is 10-bit unsigned. Parameter combinations with totals above 1024 are illegal. Simulation must flag them with `$error` at elaboration.

## Timing
- Reset values: `div_cnt`=0, `p_tick`=0 (1 if CLK_DIV=1), `pixel_x`=0, `pixel_y`=0, `video_on`=1, `hsync`=1, `vsync`=1, `frame_start`=0, `frame_count`=0.
- The first `p_tick` after reset release occurs CLK_DIV `clk` cycles later.
- Counter-to-output latency is 0: the outputs always describe the pixel currently addressed by `pixel_x`/`pixel_y`.
- Timing per pixel is CLK_DIV clocks, per line 800×CLK_DIV clocks, per frame 420000 pixel ticks.
- Reset asserted mid-frame clears all state immediately. After release, the frame restarts at (0,0) without emitting `frame_start`.

## Configuration
- `VGA_SYNC_FRAME_CNT_EN` defined: `frame_count` increments (mod 256) on the same edge that asserts `frame_start`. It is used for blink and animation timing.
- `VGA_SYNC_FRAME_CNT_EN` undefined: the counter flops are not built and `frame_count` is tied to 8'd0.

## Structure
- Shared package `vga_pkg` holds the default 640x480 timing constants and the derived H_TOTAL/V_TOTAL.
- One natural sub-module: `pixel_tick_div` (divider producing `p_tick`). Everything else stays in `vga_sync_gen`.

## Test plan
- Reset release with CLK_DIV=2: `p_tick` toggles 0,1,0,1; `pixel_x` reaches 1 after 2 clks; `hsync`=`vsync`=1, `video_on`=1.
- Line sweep: `video_on` falls when `pixel_x` goes 639→640; `hsync` is low for exactly 96 ticks from `pixel_x`=656; `pixel_x` wraps 799→0 and `pixel_y` goes 0→1 on the same edge.
- Frame sweep: `vsync` is low for `pixel_y` 490..491 only (1600 ticks); `pixel_y` wraps 524→0; `frame_start` pulses once per 420000 ticks.
- Reset asserted at (700,300) mid-line: outputs return to reset values asynchronously; the count restarts from (0,0) after release with no `frame_start` pulse.
- With `VGA_SYNC_FRAME_CNT_EN`, run 257 frames: `frame_count` reads 1 after wrap (255→0→1). Without the macro, `frame_count` stays 0 throughout.
- CLK_DIV=1: `p_tick` is constantly 1 and `pixel_x` increments every clk.
